seq_divider: RTL and testbench

Multi-cycle radix-2 restoring divider for the execute stage. It sits beside the carry-lookahead adders and consumes the same operand buses, serving DIV/DIVU in the CPU. Each trial subtraction is one adder-width operation per cycle. The pipeline stalls on the valid/ready handshake until quotient and remainder are returned.

---
 rtl/seq_divider.sv | 153 +++++++++++++++
 tb/tb_seq_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider (DIV/DIVU).
// One trial subtraction per cycle. Quotient and remainder are handed back
// over a valid/ready handshake.
//
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   in_valid / in_ready      request handshake (in_ready = idle)
//   div_signed               1 = two's-complement, 0 = unsigned
//   dividend, divisor        operands, sampled only on the accept edge
//   out_valid / out_ready    result handshake, result held until taken
//   quotient, remainder      registered results
//   div_zero                 divisor was zero (only with DIV_ZERO_CHECK_EN)
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : a zero divisor skips CALC; q=0, r=raw dividend, div_zero=1
//   undefined : no detection; div_zero tied low, zero divisor runs all steps
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one restoring step per cycle, WIDTH steps
// FIX   | apply result signs
// DONE  | result valid, waiting for out_ready
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH:0]   trial;
`ifdef DIV_ZERO_CHECK_EN
  logic             dz_q, dz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    // Borrow in the top bit means the shifted remainder is below the divisor.
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dmag_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          negq_d  = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = div_signed & dividend[WIDTH-1];
          // MIN negates to itself, which is the correct unsigned magnitude.
          quo_d   = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dmag_d  = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
          if (divisor == '0) begin
            quo_d   = '0;
            rem_d   = dividend;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            dz_d    = 1'b1;
            state_d = FIX;
          end
`endif
        end
      end
      CALC: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        if (negq_q) quo_d = -quo_q;
        if (negr_q) rem_d = -rem_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dmag_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_CHECK_EN
  assign div_zero  = dz_q;
`else
  assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=32). Latencies are counted
// with the accept edge as edge 1, so a normal result shows up after edge 34.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         div_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request with out_ready high, check latency, results and handoff.
  task automatic run_op(input string tag, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz);
    int lat;
    int exp_lat;
    exp_lat = W + 2;
`ifdef DIV_ZERO_CHECK_EN
    if (b == '0) exp_lat = 2;
`endif
    @(negedge clk);
    check({tag, " in_ready before"}, W'(in_ready), W'(1));
    in_valid   = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    out_ready  = 1'b1;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " q"}, quotient, eq);
    check({tag, " r"}, remainder, er);
    check({tag, " div_zero"}, W'(div_zero), W'(edz));
    @(posedge clk);
    #1;
    check({tag, " in_ready after"}, W'(in_ready), W'(1));
    check({tag, " out_valid after"}, W'(out_valid), W'(0));
  endtask

  initial begin
    int ov_seen;
    int lat;

    tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tbl[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    tbl[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    tbl[3]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    tbl[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    tbl[5]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    tbl[6]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    tbl[7]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0};
    tbl[8]  = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
    tbl[9]  = '{1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    tbl[10] = '{1'b0, 32'd1000,       32'd1000,       32'd1,          32'd0,          1'b0};
`ifdef DIV_ZERO_CHECK_EN
    tbl[11] = '{1'b0, 32'd7,          32'd0,          32'd0,          32'd7,          1'b1};
    tbl[12] = '{1'b1, 32'd7,          32'd0,          32'd0,          32'd7,          1'b1};
    tbl[13] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'd0,          32'hFFFFFFF9,   1'b1};
`else
    tbl[11] = '{1'b0, 32'd7,          32'd0,          32'hFFFFFFFF,   32'd7,          1'b0};
    tbl[12] = '{1'b1, 32'd7,          32'd0,          32'hFFFFFFFF,   32'd7,          1'b0};
    tbl[13] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'd1,          32'hFFFFFFF9,   1'b0};
`endif

    resetn     = 1'b0;
    in_valid   = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset q", quotient, '0);
    check("reset r", remainder, '0);
    check("reset div_zero", W'(div_zero), W'(0));
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++)
      run_op($sformatf("vec%0d", i), tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz);

    // Stall in DONE for 10 cycles while in_valid pulses are offered.
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check("stall latency", W'(lat), W'(W + 2));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = $urandom;
      divisor  = $urandom_range(1, 1000);
      @(posedge clk);
      #1;
      check("stall out_valid", W'(out_valid), W'(1));
      check("stall in_ready", W'(in_ready), W'(0));
      check("stall q", quotient, 32'd14);
      check("stall r", remainder, 32'd2);
    end
    // Handoff cycle with in_valid still high must not accept.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dividend  = 32'd5;
    divisor   = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("handoff in_ready", W'(in_ready), W'(1));
    check("handoff out_valid", W'(out_valid), W'(0));
    repeat (3) @(posedge clk);
    #1;
    check("no accept in handoff", W'(in_ready), W'(1));

    // Reset at step 15 of CALC aborts the operation.
    @(negedge clk);
    in_valid   = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("abort in_ready", W'(in_ready), W'(1));
    check("abort out_valid", W'(out_valid), W'(0));
    check("abort q", quotient, '0);
    check("abort r", remainder, '0);
    @(negedge clk);
    resetn  = 1'b1;
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen++;
    end
    check("abort no out_valid", W'(ov_seen), W'(0));
    run_op("post-reset 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
